// File: rtl/adder_4bit.sv
// -----------------------------------------------------------------------------
// adder_4bit
//   Unsigned two-operand adder that keeps the carry, so the result is one bit
//   wider than the operands. With OUT_REG=1 the sum is registered and a valid
//   flag travels with it (latency 1 clock, one result per clock, no
//   back-pressure). With OUT_REG=0 the block is purely combinational and
//   valid_o simply mirrors valid_i.
//
// Parameters
//   WIDTH    operand width in bits (1..32)
//   OUT_REG  1 = registered sum, 0 = combinational sum
//
// Ports
//   clk_i    in   1        rising-edge clock (registered mode only)
//   rst_i    in   1        asynchronous active-high reset (registered mode only)
//   valid_i  in   1        a_i/b_i carry valid operands this cycle
//   a_i      in   WIDTH    operand A, unsigned
//   b_i      in   WIDTH    operand B, unsigned
//   sum_o    out  WIDTH+1  a_i + b_i, MSB is the carry-out
//   valid_o  out  1        sum_o holds the result of valid operands
//   carry_o  out  1        copy of sum_o[WIDTH]
// -----------------------------------------------------------------------------
module adder_4bit #(
  parameter int WIDTH   = 4,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o,
  output logic             valid_o,
  output logic             carry_o
);

  // Ripple-carry addition. The final carry lands in the extra MSB, so the
  // result never wraps: the largest value is 2*(2^WIDTH-1).
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic           c;
    logic [WIDTH:0] s;
    c = 1'b0;
    s = {(WIDTH+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    s[WIDTH] = c;
    return s;
  endfunction

  logic [WIDTH:0] sum_s;

  // Full-width combinational sum of the current operands.
  always_comb begin
    sum_s = ripple_add(a_i, b_i);
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [WIDTH:0] sum_q;
      logic [WIDTH:0] sum_d;
      logic           valid_q;
      logic           valid_d;

      // Next state: capture on valid operands, otherwise hold the sum and
      // drop the valid flag.
      always_comb begin
        sum_d   = sum_q;
        valid_d = 1'b0;
        if (valid_i) begin
          sum_d   = sum_s;
          valid_d = 1'b1;
        end else begin
          sum_d   = sum_q;
          valid_d = 1'b0;
        end
      end

      // Output register; reset clears immediately and discards any result
      // that was about to be captured.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sum_q   <= {(WIDTH+1){1'b0}};
          valid_q <= 1'b0;
        end else begin
          sum_q   <= sum_d;
          valid_q <= valid_d;
        end
      end

      assign sum_o   = sum_q;
      assign carry_o = sum_q[WIDTH];
      assign valid_o = valid_q;
    end else begin : g_comb
      // Clock and reset have no function in the combinational variant.
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk_i | rst_i;

      assign sum_o   = sum_s;
      assign carry_o = sum_s[WIDTH];
      assign valid_o = valid_i;
    end
  endgenerate

endmodule

// File: tb/tb_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_adder_4bit
//   Drives a registered (OUT_REG=1) and a combinational (OUT_REG=0) instance
//   with the same operand stream. Expected sums are computed with plain
//   integer addition and queued when issued; a monitor on the falling edge
//   pops and compares whenever a DUT presents valid_o.
// -----------------------------------------------------------------------------
module tb_adder_4bit;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] a;
  logic [3:0] b;

  logic [4:0] sum_r_s, sum_c_s;
  logic       valid_r_s, valid_c_s;
  logic       carry_r_s, carry_c_s;

  int n_cmp;
  int n_bad;

  logic [4:0] q_reg[$];
  logic [4:0] q_comb[$];
  logic [4:0] last_sum;

  adder_4bit #(.WIDTH(4), .OUT_REG(1'b1)) dut_reg (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .a_i(a), .b_i(b),
    .sum_o(sum_r_s), .valid_o(valid_r_s), .carry_o(carry_r_s)
  );

  adder_4bit #(.WIDTH(4), .OUT_REG(1'b0)) dut_comb (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .a_i(a), .b_i(b),
    .sum_o(sum_c_s), .valid_o(valid_c_s), .carry_o(carry_c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one operand pair just after a rising edge.
  task automatic send(input logic v, input logic [3:0] x, input logic [3:0] y);
    int s;
    @(posedge clk);
    #1;
    valid = v;
    a     = x;
    b     = y;
    if (v) begin
      s = int'(x) + int'(y);
      q_reg.push_back(s[4:0]);
      q_comb.push_back(s[4:0]);
    end
  endtask

  // Monitor: compares both DUTs on every falling edge.
  always @(negedge clk) begin
    logic [4:0] e;
    if (valid_r_s) begin
      if (q_reg.size() == 0) begin
        check("reg_unexpected_valid", 1, 0);
      end else begin
        e = q_reg.pop_front();
        check("reg_sum", int'(sum_r_s), int'(e));
        check("reg_carry", int'(carry_r_s), int'(e[4]));
        last_sum = e;
      end
    end else begin
      check("reg_hold_sum", int'(sum_r_s), int'(last_sum));
      check("reg_hold_carry", int'(carry_r_s), int'(last_sum[4]));
    end
    if (valid_c_s) begin
      if (q_comb.size() == 0) begin
        check("comb_unexpected_valid", 1, 0);
      end else begin
        e = q_comb.pop_front();
        check("comb_sum", int'(sum_c_s), int'(e));
        check("comb_carry", int'(carry_c_s), int'(e[4]));
      end
    end else if (q_comb.size() != 0) begin
      check("comb_missing_valid", 0, 1);
      void'(q_comb.pop_front());
    end
  end

  // Assert reset between edges, shortly after operands were issued, so the
  // pending registered result must be discarded.
  task automatic mid_reset();
    #1;
    rst = 1'b1;
    q_reg.delete();
    last_sum = 5'd0;
    #1;
    check("rst_sum", int'(sum_r_s), 0);
    check("rst_valid", int'(valid_r_s), 0);
    check("rst_carry", int'(carry_r_s), 0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_sum = 5'd0;
    rst      = 1'b1;
    valid    = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    #1;
    check("init_rst_sum", int'(sum_r_s), 0);
    check("init_rst_valid", int'(valid_r_s), 0);
    check("init_rst_carry", int'(carry_r_s), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed: basic, carry, maximum, zero and identity.
    send(1'b1, 4'd3, 4'd5);
    send(1'b1, 4'd15, 4'd1);
    send(1'b1, 4'd15, 4'd15);
    send(1'b1, 4'd0, 4'd0);
    send(1'b1, 4'd9, 4'd0);
    send(1'b1, 4'd0, 4'd7);

    // Hold: one valid pulse then three idle cycles.
    send(1'b1, 4'd2, 4'd4);
    for (int i = 0; i < 3; i++) send(1'b0, 4'd11, 4'd13);

    // Reset in the middle of a stream with a nonzero sum held.
    send(1'b1, 4'd12, 4'd10);
    send(1'b1, 4'd7, 4'd8);
    mid_reset();
    send(1'b1, 4'd1, 4'd1);
    send(1'b0, 4'd0, 4'd0);

    // Exhaustive back-to-back sweep.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        send(1'b1, 4'(x), 4'(y));
      end
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 4; i++) send(1'b0, 4'd0, 4'd0);
    check("reg_queue_drained", q_reg.size(), 0);
    check("comb_queue_drained", q_comb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
